// File: rtl/dcache_pkg.sv
// Shared dcache line/burst geometry, data typedefs and the line adaptor FSM states.
package dcache_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] burst_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } adaptor_state_e;

endpackage

// File: rtl/dcache_line_adaptor.sv
// Gathers memory beats into a dcache line on fills and splits a line into beats on writebacks.
// Optional critical-word-first ordering is selected with `DCACHE_CRITICAL_WORD_FIRST_EN.
module dcache_line_adaptor
  import dcache_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_burst  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 address_i,
  input  logic                        read_i,
  input  logic                        write_i,
  input  logic [8*(2**s_offset)-1:0]  line_i,
  output logic [8*(2**s_offset)-1:0]  line_o,
  output logic                        resp_o,
  output logic [31:0]                 address_o,
  output logic                        read_o,
  output logic                        write_o,
  output logic [s_burst-1:0]          burst_o,
  input  logic [s_burst-1:0]          burst_i,
  input  logic                        resp_i
);

  localparam int line_w = 8 * (2 ** s_offset);
  localparam int beats  = line_w / s_burst;
  localparam int cnt_w  = $clog2(beats);

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  localparam int addr_lsb = s_offset - cnt_w;
`else
  localparam int addr_lsb = s_offset;
`endif
  localparam logic [31:0] addr_mask = ~((32'd1 << addr_lsb) - 32'd1);

  adaptor_state_e      state, state_next;
  logic [cnt_w-1:0]    cnt;
  logic [cnt_w-1:0]    start_q;
  logic [cnt_w-1:0]    start_in;
  logic [cnt_w-1:0]    idx;
  logic [31:0]         addr_q;
  logic [line_w-1:0]   buffer;
  logic [line_w-1:0]   line_q;
  logic                last_beat;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  assign start_in = address_i[s_offset-1 -: cnt_w];
`else
  assign start_in = '0;
`endif

  // Beat index wraps naturally in cnt_w bits, giving the wrapped burst order.
  assign idx       = start_q + cnt;
  assign last_beat = resp_i && (cnt == cnt_w'(beats - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the line and write buffers are cleared on reset so an aborted fill
  // never leaves a partial line visible on line_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      start_q <= '0;
      addr_q  <= '0;
      buffer  <= '0;
      line_q  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (write_i) begin
            buffer  <= line_i;
            addr_q  <= address_i & addr_mask;
            start_q <= start_in;
            cnt     <= '0;
          end else if (read_i) begin
            addr_q  <= address_i & addr_mask;
            start_q <= start_in;
            cnt     <= '0;
          end
        end
        RD: begin
          if (resp_i) begin
            line_q[int'(idx)*s_burst +: s_burst] <= burst_i;
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write_i)     state_next = WR;
        else if (read_i) state_next = RD;
      end
      RD:      if (last_beat) state_next = DONE;
      WR:      if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    burst_o   = '0;
    address_o = addr_q;
    line_o    = line_q;
    case (state)
      RD:   read_o = 1'b1;
      WR: begin
        write_o = 1'b1;
        burst_o = buffer[int'(idx)*s_burst +: s_burst];
      end
      DONE: resp_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_line_adaptor.sv
// Self-checking bench for dcache_line_adaptor: transaction-level model plus per-cycle compare.
module tb_dcache_line_adaptor;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address_i;
  logic        read_i, write_i;
  line_t       line_i, line_o;
  logic        resp_o;
  logic [31:0] address_o;
  logic        read_o, write_o;
  burst_t      burst_o, burst_i;
  logic        resp_i;

  always #5 clk = ~clk;

  dcache_line_adaptor dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int resp_seen = 0;
  int resp_cyc  = -1;

  // Expected visible outputs for the current cycle
  logic        cmp_en = 1'b0;
  logic        exp_read, exp_write, exp_resp;
  burst_t      exp_burst;
  logic [31:0] exp_addr;
  line_t       exp_line;
  burst_t      wb_beats[$];

  task automatic check(input string name, input line_t act, input line_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("read_o",    line_t'(read_o),    line_t'(exp_read));
      check("write_o",   line_t'(write_o),   line_t'(exp_write));
      check("resp_o",    line_t'(resp_o),    line_t'(exp_resp));
      check("address_o", line_t'(address_o), line_t'(exp_addr));
      check("line_o",    line_o,             exp_line);
      if (exp_write) check("burst_o", line_t'(burst_o), line_t'(exp_burst));
    end
    if (resp_o === 1'b1) begin
      resp_seen++;
      resp_cyc = cyc;
    end
  end

  // Model rules: memory address alignment and wrapped beat order
  function automatic logic [31:0] mem_addr(input logic [31:0] a);
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    return {a[31:3], 3'b000};
`else
    return {a[31:5], 5'b00000};
`endif
  endfunction

  function automatic int beat_at(input logic [31:0] a, input int k);
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    return (int'(a[4:3]) + k) % BEATS;
`else
    return k % BEATS;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic r, input logic w, input logic d);
    exp_read  = r;
    exp_write = w;
    exp_resp  = d;
  endtask

  task automatic fill(input logic [31:0] a, input burst_t w[BEATS], input int stalls);
    int b;
    read_i = 1'b1; write_i = 1'b0; address_i = a; resp_i = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    exp_addr = mem_addr(a);
    for (int k = 0; k < BEATS; k++) begin
      b = beat_at(a, k);
      for (int s = 0; s < stalls; s++) begin
        resp_i = 1'b0; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        set_exp(1'b1, 1'b0, 1'b0);
        step();
      end
      resp_i = 1'b1; burst_i = w[b];
      set_exp(1'b1, 1'b0, 1'b0);
      step();
      exp_line[b*BURST_W +: BURST_W] = w[b];
    end
    resp_i = 1'b0; burst_i = '0;
    set_exp(1'b0, 1'b0, 1'b1);
    step();
    read_i = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic writeback(input logic [31:0] a, input line_t l, input int stalls,
                           input logic also_read);
    int b;
    write_i = 1'b1; read_i = also_read; address_i = a; line_i = l; resp_i = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    line_i = '0;
    exp_addr = mem_addr(a);
    wb_beats.delete();
    for (int k = 0; k < BEATS; k++) begin
      b = beat_at(a, k);
      exp_burst = l[b*BURST_W +: BURST_W];
      for (int s = 0; s < stalls; s++) begin
        resp_i = 1'b0;
        set_exp(1'b0, 1'b1, 1'b0);
        step();
      end
      resp_i = 1'b1;
      set_exp(1'b0, 1'b1, 1'b0);
      wb_beats.push_back(burst_o);
      step();
    end
    resp_i = 1'b0;
    set_exp(1'b0, 1'b0, 1'b1);
    step();
    write_i = 1'b0; read_i = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    burst_t w1[BEATS];
    burst_t w2[BEATS];
    line_t  lit;
    int     base, req_cyc;

    rst = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    line_i = '0; burst_i = '0; resp_i = 1'b0;
    exp_addr = '0; exp_line = '0; exp_burst = '0;
    set_exp(1'b0, 1'b0, 1'b0);

    // Reset held two cycles
    step();
    cmp_en = 1'b1;
    check("rst_state", line_t'(dut.state), line_t'(IDLE));
    check("rst_burst_o", line_t'(burst_o), '0);
    step();
    rst = 1'b0;

    // Fill, no stalls
    w1 = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
    base = resp_seen;
    req_cyc = cyc;
    fill(32'h0000_1040, w1, 0);
    lit = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    check("fill_line_lit", line_o, lit);
    check("fill_addr_lit", line_t'(address_o), line_t'(32'h0000_1040));
    check("fill_resp_count", line_t'(resp_seen - base), line_t'(1));
    check("fill_resp_at_t5", line_t'(resp_cyc - req_cyc), line_t'(5));

    // Writeback with three stall cycles before every beat
    lit = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
    base = resp_seen;
    writeback(32'h0000_2000, lit, 3, 1'b0);
    check("wb_resp_count", line_t'(resp_seen - base), line_t'(1));
    check("wb_beat0_lit", line_t'(wb_beats[0]), line_t'(64'hAAAAAAAAAAAAAAAA));
    check("wb_beat3_lit", line_t'(wb_beats[3]), line_t'(64'hDDDDDDDDDDDDDDDD));

    // Simultaneous read and write: write wins
    writeback(32'h0000_2400, {64'h0404, 64'h0303, 64'h0202, 64'h0101}, 0, 1'b1);

    // Mid-burst reset after two fill beats
    read_i = 1'b1; address_i = 32'h0000_3000; resp_i = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    exp_addr = mem_addr(32'h0000_3000);
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = 64'h9999_0000_0000_0000 | 64'(k);
      set_exp(1'b1, 1'b0, 1'b0);
      step();
      exp_line[beat_at(32'h0000_3000, k)*BURST_W +: BURST_W] = 64'h9999_0000_0000_0000 | 64'(k);
    end
    base = resp_seen;
    rst = 1'b1; resp_i = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b0; read_i = 1'b0; resp_i = 1'b0;
    exp_addr = '0; exp_line = '0;
    set_exp(1'b0, 1'b0, 1'b0);
    check("rst_mid_state", line_t'(dut.state), line_t'(IDLE));
    step();
    step();
    check("rst_mid_no_resp", line_t'(resp_seen - base), line_t'(0));
    fill(32'h0000_3000, w1, 1);
    check("post_rst_line_lit", line_o,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Mid-line address: critical word first when enabled, aligned line otherwise
    w2 = '{64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777, 64'h8888888888888888};
    fill(32'h0000_1050, w2, 0);
    check("cwf_line_lit", line_o,
          256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555);
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    check("cwf_addr_lit", line_t'(address_o), line_t'(32'h0000_1050));
    writeback(32'h0000_1050, 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA, 0, 1'b0);
    check("cwf_wb_first_lit", line_t'(wb_beats[0]), line_t'(64'hCCCCCCCCCCCCCCCC));
`else
    check("line_addr_lit", line_t'(address_o), line_t'(32'h0000_1040));
`endif

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
